wbs_uart_tx: RTL

Wishbone B4 pipelined slave that queues bytes written by the bus master into a FIFO and serialises them as 8N1 UART frames on one output pin. It sits directly downstream of the SPI-controlled Wishbone master, so an MCU can emit serial text through the FPGA with three SPI-bridged register accesses. Everything runs on the Wishbone clock.

---
 rtl/wbs_uart_tx.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/wbs_uart_tx.sv
// Wishbone B4 pipelined slave feeding a byte FIFO into an 8N1 UART transmitter.
// Ack one cycle after each request, never stalls; writes to a full FIFO are dropped and flag overflow.

module wbs_uart_tx_fifo #(
  parameter int W    = 8,
  parameter int LOG2 = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_vld_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_vld_i,
  output logic [W-1:0]  pop_dat_o,
  output logic [LOG2:0] level_o,
  output logic          empty_o,
  output logic          full_o
);
  logic [W-1:0]    mem_q [2**LOG2];
  logic [LOG2-1:0] wr_ptr_q;
  logic [LOG2-1:0] rd_ptr_q;
  logic [LOG2:0]   level_q;
  logic            push_ok;
  logic            pop_ok;

  // Full is judged on the registered level, so a same-cycle pop never makes room for a push.
  assign full_o    = level_q[LOG2];
  assign empty_o   = (level_q == '0);
  assign push_ok   = push_vld_i && !full_o;
  assign pop_ok    = pop_vld_i && !empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + LOG2'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + LOG2'(1);
      end
      level_q <= level_q + (LOG2+1)'(push_ok) - (LOG2+1)'(pop_ok);
    end
  end
endmodule

module wbs_uart_tx #(
  parameter int FIFO_LOG2 = 4,
  parameter int DIV_RESET = 104
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [15:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_stall_o,
  output logic        wb_ack_o,
  output logic        uart_tx
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e             state_q;
  logic [15:0]        div_q;
  logic [15:0]        div_d;
  logic [15:0]        cnt_q;
  logic [15:0]        period_m1;
  logic [7:0]         sh_q;
  logic [2:0]         bit_q;
  logic               tx_q;
  logic               ovf_q;
  logic               ovf_d;
  logic               ack_q;
  logic [31:0]        dat_q;
  logic [31:0]        rd_dat;
  logic               req;
  logic               wr_data;
  logic               wr_stat;
  logic               wr_baud;
  logic               busy;
  logic               bit_end;
  logic               fifo_pop_vld;
  logic [7:0]         fifo_pop_dat;
  logic [FIFO_LOG2:0] fifo_level;
  logic               fifo_empty;
  logic               fifo_full;
  logic               unused_bits;

  assign req     = wb_cyc_i && wb_stb_i;
  assign wr_data = req && wb_we_i && (wb_adr_i[3:2] == 2'd0) && wb_sel_i[0];
  assign wr_stat = req && wb_we_i && (wb_adr_i[3:2] == 2'd1);
  assign wr_baud = req && wb_we_i && (wb_adr_i[3:2] == 2'd2);
  assign busy    = (state_q != IDLE);

  // A zero divisor runs at one cycle per bit rather than stalling the counter.
  assign period_m1    = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
  assign bit_end      = (cnt_q == 16'd0);
  assign fifo_pop_vld = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && bit_end));

  assign unused_bits = ^{wb_adr_i[15:4], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};

  wbs_uart_tx_fifo #(
    .W    (8),
    .LOG2 (FIFO_LOG2)
  ) u_fifo (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .push_vld_i (wr_data),
    .push_dat_i (wb_dat_i[7:0]),
    .pop_vld_i  (fifo_pop_vld),
    .pop_dat_o  (fifo_pop_dat),
    .level_o    (fifo_level),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  always_comb begin
    div_d = div_q;
    if (wr_baud && wb_sel_i[0]) div_d[7:0]  = wb_dat_i[7:0];
    if (wr_baud && wb_sel_i[1]) div_d[15:8] = wb_dat_i[15:8];

    // Set is applied last so it wins over a coincident clear.
    ovf_d = ovf_q;
    if (wr_stat && wb_sel_i[0] && wb_dat_i[3]) ovf_d = 1'b0;
    if (wr_data && fifo_full) ovf_d = 1'b1;

    rd_dat = '0;
    case (wb_adr_i[3:2])
      2'd1: begin
        rd_dat[0]                 = busy;
        rd_dat[1]                 = fifo_empty;
        rd_dat[2]                 = fifo_full;
        rd_dat[3]                 = ovf_q;
        rd_dat[8 +: FIFO_LOG2+1]  = fifo_level;
      end
      2'd2:    rd_dat[15:0] = div_q;
      default: rd_dat = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      div_q <= 16'(DIV_RESET);
      ovf_q <= 1'b0;
    end else begin
      ack_q <= req;
      dat_q <= (req && !wb_we_i) ? rd_dat : '0;
      div_q <= div_d;
      ovf_q <= ovf_d;
    end
  end

  // Bit counter reloads from the live divisor at every bit boundary.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            sh_q    <= fifo_pop_dat;
            tx_q    <= 1'b0;
            cnt_q   <= period_m1;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx_q    <= sh_q[0];
            bit_q   <= '0;
            cnt_q   <= period_m1;
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= period_m1;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tx_q  <= sh_q[1];
              sh_q  <= {1'b0, sh_q[7:1]};
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!fifo_empty) begin
              sh_q    <= fifo_pop_dat;
              tx_q    <= 1'b0;
              cnt_q   <= period_m1;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign wb_stall_o = 1'b0;
  assign uart_tx    = tx_q;
endmodule
